// File: rtl/ber_sweep_ctrl.sv
// BER sweep sequencer: steps noise_magnitude, settles, measures bits/errors per step.
// Optional watchdog on MEASURE is compiled in with BER_SWEEP_TIMEOUT_EN.
module ber_sweep_ctrl #(
   parameter int NOISE_MAG_WIDTH = 8,
   parameter int CNT_WIDTH       = 32,
   parameter int BITS_PER_SYM    = 4,
   parameter int ERR_WIDTH       = 3,
   parameter int SETTLE_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES  = 65536
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [NOISE_MAG_WIDTH-1:0] cfg_mag_start,
   input  logic [NOISE_MAG_WIDTH-1:0] cfg_mag_step,
   input  logic [NOISE_MAG_WIDTH-1:0] cfg_mag_stop,
   input  logic [CNT_WIDTH-1:0]       cfg_dwell,
   input  logic                       sym_valid,
   input  logic [ERR_WIDTH-1:0]       err_bits,
   output logic [NOISE_MAG_WIDTH-1:0] noise_magnitude,
   output logic                       busy,
   output logic                       done,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [NOISE_MAG_WIDTH-1:0] res_mag,
   output logic [CNT_WIDTH-1:0]       res_bits,
   output logic [CNT_WIDTH-1:0]       res_errs,
   output logic                       timeout
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int MW = NOISE_MAG_WIDTH;
   localparam int CW = CNT_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE,
      S_REPORT,
      S_DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [MW-1:0] mag;
   logic [MW-1:0] mag_n;
   logic [MW-1:0] step_q;
   logic [MW-1:0] step_n;
   logic [MW-1:0] stop_q;
   logic [MW-1:0] stop_n;
   logic [CW-1:0] dwell_q;
   logic [CW-1:0] dwell_n;
   logic [SW-1:0] settle;
   logic [SW-1:0] settle_n;
   logic [CW-1:0] sym_cnt;
   logic [CW-1:0] sym_cnt_n;
   logic [CW-1:0] bits_q;
   logic [CW-1:0] bits_n;
   logic [CW-1:0] errs_q;
   logic [CW-1:0] errs_n;
   logic [MW-1:0] rmag;
   logic [MW-1:0] rmag_n;
   logic [CW-1:0] rbits;
   logic [CW-1:0] rbits_n;
   logic [CW-1:0] rerrs;
   logic [CW-1:0] rerrs_n;
   logic          to_q;
   logic          to_n;
   logic          wd_fire;

   logic [MW:0]   sum;
   logic [CW:0]   bits_add;
   logic [CW:0]   errs_add;
   logic [CW-1:0] bits_sat;
   logic [CW-1:0] errs_sat;
   logic [CW-1:0] sym_inc;
   logic          last_pt;

   // Wide sums so the counters saturate instead of wrapping.
   assign bits_add = {1'b0, bits_q} + (CW+1)'(BITS_PER_SYM);
   assign errs_add = {1'b0, errs_q} + (CW+1)'(err_bits);
   assign bits_sat = bits_add[CW] ? '1 : bits_add[CW-1:0];
   assign errs_sat = errs_add[CW] ? '1 : errs_add[CW-1:0];
   assign sym_inc  = sym_cnt + CW'(1);

   assign sum      = {1'b0, mag} + {1'b0, step_q};
   assign last_pt  = (step_q == '0) ||
                     (sum > {1'b0, stop_q}) ||
                     (mag >= stop_q);

`ifdef BER_SWEEP_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WW-1:0] wd;
   logic [WW-1:0] wd_n;

   always_comb begin
      wd_n    = '0;
      wd_fire = 1'b0;
      if (state == S_MEASURE && !sym_valid) begin
         if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
            wd_fire = 1'b1;
         end else begin
            wd_n = wd + WW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd <= '0;
      end else begin
         wd <= wd_n;
      end
   end
`else
   logic unused_to;

   assign unused_to = (TIMEOUT_CYCLES > 0);
   assign wd_fire   = 1'b0;
`endif

   always_comb begin
      state_n   = state;
      mag_n     = mag;
      step_n    = step_q;
      stop_n    = stop_q;
      dwell_n   = dwell_q;
      settle_n  = settle;
      sym_cnt_n = sym_cnt;
      bits_n    = bits_q;
      errs_n    = errs_q;
      rmag_n    = rmag;
      rbits_n   = rbits;
      rerrs_n   = rerrs;
      to_n      = to_q;

      unique case (state)
         S_IDLE: begin
            mag_n = '0;
            if (start && !abort) begin
               step_n   = cfg_mag_step;
               stop_n   = cfg_mag_stop;
               dwell_n  = (cfg_dwell == '0) ? CW'(1) : cfg_dwell;
               mag_n    = cfg_mag_start;
               settle_n = SW'(SETTLE_CYCLES);
               to_n     = 1'b0;
               state_n  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle <= SW'(1)) begin
               settle_n  = '0;
               sym_cnt_n = '0;
               bits_n    = '0;
               errs_n    = '0;
               state_n   = S_MEASURE;
            end else begin
               settle_n = settle - SW'(1);
            end
         end
         S_MEASURE: begin
            if (sym_valid) begin
               sym_cnt_n = sym_inc;
               bits_n    = bits_sat;
               errs_n    = errs_sat;
               if (sym_inc == dwell_q) begin
                  rmag_n  = mag;
                  rbits_n = bits_sat;
                  rerrs_n = errs_sat;
                  state_n = S_REPORT;
               end
            end
         end
         S_REPORT: begin
            if (res_ready) begin
               if (last_pt) begin
                  state_n = S_DONE;
               end else begin
                  mag_n    = sum[MW-1:0];
                  settle_n = SW'(SETTLE_CYCLES);
                  state_n  = S_SETTLE;
               end
            end
         end
         S_DONE: begin
            mag_n   = '0;
            state_n = S_IDLE;
         end
         default: begin
            mag_n   = '0;
            state_n = S_IDLE;
         end
      endcase

      // Abort and watchdog both drop straight back to IDLE with no done pulse.
      if (abort || wd_fire) begin
         mag_n   = '0;
         state_n = S_IDLE;
      end
      if (wd_fire) begin
         to_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         mag     <= '0;
         step_q  <= '0;
         stop_q  <= '0;
         dwell_q <= '0;
         settle  <= '0;
         sym_cnt <= '0;
         bits_q  <= '0;
         errs_q  <= '0;
         rmag    <= '0;
         rbits   <= '0;
         rerrs   <= '0;
         to_q    <= 1'b0;
      end else begin
         state   <= state_n;
         mag     <= mag_n;
         step_q  <= step_n;
         stop_q  <= stop_n;
         dwell_q <= dwell_n;
         settle  <= settle_n;
         sym_cnt <= sym_cnt_n;
         bits_q  <= bits_n;
         errs_q  <= errs_n;
         rmag    <= rmag_n;
         rbits   <= rbits_n;
         rerrs   <= rerrs_n;
         to_q    <= to_n;
      end
   end

   assign noise_magnitude = mag;
   assign busy            = (state != S_IDLE);
   assign done            = (state == S_DONE);
   assign res_valid       = (state == S_REPORT);
   assign res_mag         = rmag;
   assign res_bits        = rbits;
   assign res_errs        = rerrs;
   assign timeout         = to_q;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// Scoreboard bench for ber_sweep_ctrl: sweep-level model feeds an expected-result
// queue, a negedge monitor checks every presented result against it.
module tb_ber_sweep_ctrl;

   localparam int NW  = 8;
   localparam int CW  = 32;
   localparam int BPS = 4;
   localparam int EW  = 3;
   localparam int SC  = 16;
   localparam int TO  = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [NW-1:0] cfg_mag_start;
   logic [NW-1:0] cfg_mag_step;
   logic [NW-1:0] cfg_mag_stop;
   logic [CW-1:0] cfg_dwell;
   logic          sym_valid;
   logic [EW-1:0] err_bits;
   logic [NW-1:0] noise_magnitude;
   logic          busy;
   logic          done;
   logic          res_valid;
   logic          res_ready;
   logic [NW-1:0] res_mag;
   logic [CW-1:0] res_bits;
   logic [CW-1:0] res_errs;
   logic          timeout;

   ber_sweep_ctrl #(
      .NOISE_MAG_WIDTH(NW),
      .CNT_WIDTH(CW),
      .BITS_PER_SYM(BPS),
      .ERR_WIDTH(EW),
      .SETTLE_CYCLES(SC),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .cfg_mag_start(cfg_mag_start),
      .cfg_mag_step(cfg_mag_step),
      .cfg_mag_stop(cfg_mag_stop),
      .cfg_dwell(cfg_dwell),
      .sym_valid(sym_valid),
      .err_bits(err_bits),
      .noise_magnitude(noise_magnitude),
      .busy(busy),
      .done(done),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_mag(res_mag),
      .res_bits(res_bits),
      .res_errs(res_errs),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     mag;
      longint bits;
      longint errs;
   } res_t;

   res_t sb[$];
   int   errors    = 0;
   int   checks    = 0;
   int   exp_done  = 0;
   int   done_seen = 0;
   int   sv_mode   = 0;
   int   rdy_mode  = 0;
   int   err_val   = 0;
   int   hold      = 0;
   bit   scramble  = 0;
   bit   unscored  = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: list of points from the latched config, constant err per symbol.
   task automatic model_sweep(input int s, input int st, input int sp,
                              input longint dw, input int e);
      int     m;
      longint d;
      longint b;
      longint r;
      longint cap;
      cap = (longint'(1) << CW) - 1;
      d = (dw == 0) ? 1 : dw;
      b = d * BPS;
      r = d * e;
      if (b > cap) b = cap;
      if (r > cap) r = cap;
      m = s;
      forever begin
         sb.push_back('{m, b, r});
         if (st == 0 || m + st > sp || m >= sp) break;
         m = m + st;
      end
      exp_done++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      case (sv_mode)
         0:       sym_valid = 1'b0;
         1:       sym_valid = 1'b1;
         default: sym_valid = 1'($urandom % 2);
      endcase
      err_bits = EW'(err_val);
      case (rdy_mode)
         0: res_ready = 1'b0;
         1: res_ready = 1'b1;
         2: res_ready = 1'($urandom % 2);
         default: begin
            if (res_valid) hold++;
            else hold = 0;
            res_ready = (hold > 20);
         end
      endcase
      if (scramble) begin
         cfg_mag_start = NW'($urandom);
         cfg_mag_step  = NW'($urandom);
         cfg_mag_stop  = NW'($urandom);
         cfg_dwell     = CW'($urandom);
      end
   endtask

   task automatic do_start(input int s, input int st, input int sp,
                           input longint dw, input int e, input bit score);
      cfg_mag_start = NW'(s);
      cfg_mag_step  = NW'(st);
      cfg_mag_stop  = NW'(sp);
      cfg_dwell     = CW'(dw);
      err_val       = e;
      if (score) model_sweep(s, st, sp, dw, e);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      if (busy) begin
         errors++;
         checks++;
         $display("FAIL sweep_budget: busy=%0d after %0d cycles required 0", busy, n);
         abort = 1'b1;
         tick();
         abort = 1'b0;
      end
   endtask

   // Monitor: every presented result must match the head of the scoreboard.
   bit prev_done = 0;
   always @(negedge clk) begin
      if (rst) begin
         prev_done = 0;
      end else begin
         if (prev_done) begin
            chk("busy_after_done", busy, 0);
            chk("mag_after_done", noise_magnitude, 0);
         end
         if (done) begin
            done_seen++;
            chk("busy_with_done", busy, 1);
         end
         prev_done = done;
         if (res_valid && !unscored) begin
            if (sb.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_result: res_mag=%0d required none", res_mag);
            end else begin
               chk("res_mag", res_mag, sb[0].mag);
               chk("res_bits", res_bits, sb[0].bits);
               chk("res_errs", res_errs, sb[0].errs);
               chk("noise_in_report", noise_magnitude, sb[0].mag);
               if (res_ready) begin
                  chk("timeout_clear", timeout, 0);
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_watchdog: simulation time exceeded");
      $fatal(1);
   end

   initial begin
      int first_n;
      int n;
      int s;
      int st;
      int sp;
      rst           = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      cfg_mag_start = '0;
      cfg_mag_step  = '0;
      cfg_mag_stop  = '0;
      cfg_dwell     = '0;
      sym_valid     = 1'b0;
      err_bits      = '0;
      res_ready     = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_noise", noise_magnitude, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_res", {res_mag, res_bits, res_errs}, 0);
      chk("rst_timeout", timeout, 0);
      rst = 1'b0;

      // Basic three-point sweep, cfg scrambled after start.
      sv_mode = 1; rdy_mode = 1; scramble = 1;
      do_start(10, 20, 50, 100, 1, 1);
      chk("noise_first", noise_magnitude, 10);
      wait_idle(5000);
      scramble = 0;

      // Settle latency: errors inside SETTLE must not be counted.
      sv_mode = 1; rdy_mode = 1;
      do_start(5, 0, 5, 4, 3, 0);
      model_sweep(5, 0, 5, 4, 1);
      first_n = -1;
      n = 0;
      while (n < 60 && first_n < 0) begin
         err_val = (n + 2 <= SC) ? 3 : 1;
         tick();
         n++;
         if (res_valid) first_n = n;
      end
      chk("settle_latency", first_n, SC + 4);
      wait_idle(200);

      // Backpressure held for 20 cycles on every point.
      sv_mode = 2; rdy_mode = 3; hold = 0;
      do_start(0, 100, 200, 10, 2, 1);
      wait_idle(3000);

      // Edge configurations.
      sv_mode = 2; rdy_mode = 2;
      do_start(7, 0, 200, 5, 4, 1);
      wait_idle(1000);
      do_start(200, 30, 100, 6, 2, 1);
      wait_idle(1000);
      do_start(250, 10, 255, 3, 1, 1);
      wait_idle(1000);
      do_start(40, 5, 60, 0, 3, 1);
      wait_idle(2000);

      // Aborts: MEASURE, REPORT under backpressure, start+abort in IDLE.
      unscored = 1;
      sv_mode = 0; rdy_mode = 0;
      do_start(30, 10, 90, 50, 1, 0);
      repeat (25) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_meas_busy", busy, 0);
      chk("abort_meas_noise", noise_magnitude, 0);
      sv_mode = 1;
      do_start(30, 10, 90, 3, 1, 0);
      n = 0;
      while (!res_valid && n < 60) begin
         tick();
         n++;
      end
      chk("report_reached", res_valid, 1);
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_rep_valid", res_valid, 0);
      chk("abort_rep_busy", busy, 0);
      chk("abort_rep_noise", noise_magnitude, 0);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", busy, 0);

      // Reset in the middle of a sweep.
      do_start(60, 10, 90, 8, 1, 0);
      repeat (30) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", res_valid, 0);
      chk("midrst_noise", noise_magnitude, 0);

      // Watchdog with no symbols in MEASURE.
      sv_mode = 0;
      do_start(20, 0, 20, 5, 1, 0);
      repeat (SC + TO + 10) tick();
`ifdef BER_SWEEP_TIMEOUT_EN
      chk("wd_busy", busy, 0);
      chk("wd_timeout", timeout, 1);
      chk("wd_noise", noise_magnitude, 0);
      repeat (5) tick();
      chk("wd_sticky", timeout, 1);
      unscored = 0;
      sv_mode = 1; rdy_mode = 1;
      do_start(20, 0, 20, 5, 1, 1);
      chk("wd_cleared", timeout, 0);
      wait_idle(200);
`else
      chk("nowd_busy", busy, 1);
      chk("nowd_timeout", timeout, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("nowd_abort", busy, 0);
`endif
      unscored = 0;

      // Randomised sweeps.
      for (int k = 0; k < 8; k++) begin
         s  = int'($urandom_range(0, 255));
         st = ($urandom % 4 == 0) ? 0 : int'($urandom_range(16, 80));
         sp = int'($urandom_range(0, 255));
         sv_mode = 2; rdy_mode = 2; scramble = 1;
         do_start(s, st, sp, longint'($urandom_range(0, 20)),
                  int'($urandom_range(0, 4)), 1);
         wait_idle(20000);
      end
      scramble = 0;
      repeat (3) tick();

      chk("done_count", done_seen, exp_done);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ber_sweep_ctrl.md
Name: ber_sweep_ctrl

Overview:
Sequencer for the in-FPGA BER sweep. It drives noise_magnitude into the AWGN channel and steps it from a start value to a stop value. At each step it waits for the channel/RX pipeline to flush, then counts bits and bit errors over a fixed dwell of received symbols. Each per-step result is returned over a valid/ready result port for capture by the SoC/logger.

Parameters:
NOISE_MAG_WIDTH, 8, width of the noise_magnitude control word
CNT_WIDTH, 32, width of the dwell, bit and error counters
BITS_PER_SYM, 4, bits per symbol (16-QAM)
ERR_WIDTH, 3, width of the per-symbol bit-error count (0..BITS_PER_SYM)
SETTLE_CYCLES, 16, clocks to wait after a magnitude change before measuring (covers the 4-cycle channel latency plus RX pipeline)
TIMEOUT_CYCLES, 65536, watchdog limit; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  pulse; begins a sweep when the block is idle
abort  in  1  pulse; cancels the sweep
cfg_mag_start  in  NOISE_MAG_WIDTH  first magnitude
cfg_mag_step  in  NOISE_MAG_WIDTH  increment per step
cfg_mag_stop  in  NOISE_MAG_WIDTH  last magnitude (inclusive)
cfg_dwell  in  CNT_WIDTH  symbols measured per step
sym_valid  in  1  one compared RX symbol this cycle
err_bits  in  ERR_WIDTH  bit errors in that symbol
noise_magnitude  out  NOISE_MAG_WIDTH  to channel noise control
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at sweep completion
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_mag  out  NOISE_MAG_WIDTH  magnitude of this result
res_bits  out  CNT_WIDTH  bits measured
res_errs  out  CNT_WIDTH  bit errors measured
timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; counters 0.
- Configuration latching: the cfg_* inputs are captured on the accepted start only. Later changes to cfg_* have no effect until the next start.
- IDLE:
  - noise_magnitude=0.
  - start=1 and abort=0: latch cfg, load noise_magnitude=cfg_mag_start, load settle counter=SETTLE_CYCLES, go to SETTLE.
  - cfg_dwell=0 is latched as 1.
- SETTLE:
  - Settle counter decrements once per clk. sym_valid is ignored.
  - When the counter reaches 0: clear the symbol, bit and error counters, go to MEASURE. Total SETTLE dwell is exactly SETTLE_CYCLES clocks.
- MEASURE, on each sym_valid:
  - sym_cnt+=1.
  - bits+=BITS_PER_SYM.
  - errs+=err_bits.
  - bits and errs saturate at all-ones and never wrap.
  - On the cycle sym_valid brings sym_cnt to the latched dwell: the final symbol is included, the result registers are loaded, and the state goes to REPORT.
- REPORT:
  - res_valid=1; res_mag/res_bits/res_errs are held stable until the handshake.
  - Handshake = res_valid & res_ready. On the handshake, res_valid drops the next cycle.
  - Next step sum = noise_magnitude + step, computed at NOISE_MAG_WIDTH+1 bits.
  - If step==0, or the sum > latched stop, or noise_magnitude >= latched stop: go to DONE.
  - Otherwise noise_magnitude <= sum, reload the settle counter, go to SETTLE.
  - sym_valid is ignored in REPORT.
- DONE: done=1 for exactly one cycle, then IDLE (noise_magnitude returns to 0).
- start>stop at latch time: exactly one point is measured, at start.
- start while busy: ignored.
- abort:
  - Takes effect from any state. The next state is IDLE; res_valid is cleared without a handshake; noise_magnitude=0; done is not pulsed.
  - abort wins over start, sym_valid and a res handshake in the same cycle.
- rst mid-sweep: identical to the reset values above; any pending result is lost.
- The timeout output is 0 when the optional feature is compiled out.

Optional Feature:
BER_SWEEP_TIMEOUT_EN
- Defined:
  - A watchdog counter runs in MEASURE and resets on every sym_valid.
  - Reaching TIMEOUT_CYCLES with no sym_valid sets timeout=1 and forces IDLE, with abort semantics.
  - timeout is sticky; it is cleared only by rst or by the next accepted start.
- Undefined: no watchdog logic is synthesised, timeout is tied to 0, and MEASURE waits indefinitely.

Test Plan:
1. start with mag 10/20/50, dwell=100, sym_valid every cycle, err_bits=1, res_ready=1 -> three results with res_mag 10, 30, 50; each res_bits=400, res_errs=100; noise_magnitude 10→30→50→0; one done pulse; busy falls together with done.
2. Settle check: cfg dwell=4, sym_valid high continuously from start -> first counted symbol is the one SETTLE_CYCLES+1 clocks after start; symbols during SETTLE and REPORT are not counted.
3. Backpressure: res_ready=0 for 20 cycles in REPORT -> res_valid and result fields stay stable for 20 cycles; noise_magnitude is unchanged; sweep resumes on the cycle after ready.
4. Edge configs: step=0 gives one result. start=200, stop=100 gives one result at 200. start=250, step=10, stop=255 gives one result (sum 260 > stop, no wrap). dwell=0 gives res_bits=4.
5. Abort during MEASURE and during REPORT with res_ready=0 -> next cycle busy=0, res_valid=0, noise_magnitude=0, no done. A simultaneous start+abort in IDLE stays IDLE.
6. With BER_SWEEP_TIMEOUT_EN and TIMEOUT_CYCLES=32, sym_valid held low in MEASURE -> timeout=1 after 32 cycles, IDLE, timeout stays set until the next start. Without the macro: timeout=0 and busy stays high.
